// File: rtl/mem_requester_if.sv
// Request/response and memory-side signal bundle for mem_requester.
// slave is the requester's own view; master is the core/memory environment view.
interface mem_requester_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_we_i;
    logic [AWIDTH-1:0] req_addr_i;
    logic [1:0]        req_size_i;
    logic              req_unsigned_i;
    logic [DWIDTH-1:0] req_wdata_i;
    logic              rsp_valid_o;
    logic              rsp_err_o;
    logic [DWIDTH-1:0] rsp_rdata_o;
    logic [AWIDTH-1:0] mem_addr_o;
    logic [DWIDTH-1:0] mem_data_o;
    logic              mem_read_en_o;
    logic              mem_write_en_o;
    logic [DWIDTH-1:0] mem_data_i;

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_size_i, req_unsigned_i, req_wdata_i,
        input  mem_data_i,
        output req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o,
        output mem_addr_o, mem_data_o, mem_read_en_o, mem_write_en_o
    );

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_size_i, req_unsigned_i, req_wdata_i,
        output mem_data_i,
        input  req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o,
        input  mem_addr_o, mem_data_o, mem_read_en_o, mem_write_en_o
    );
endinterface

// File: rtl/mem_requester.sv
// Load/store initiator: one request at a time, sub-word stores done as read-modify-write.
// Define MISALIGN_TRAP_EN to reject misaligned half/word accesses with rsp_err_o.
module mem_requester #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_requester_if.slave       bus
);
    localparam int LANES = DWIDTH / 8;

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

    state_t            state_reg, state_next;
    logic              we_reg;
    logic [AWIDTH-1:0] addr_reg;
    logic [1:0]        size_reg;
    logic              uns_reg;
    logic [DWIDTH-1:0] wdata_reg;
    logic [DWIDTH-1:0] old_reg;
    logic              err_reg;

    logic              req_bad;
    logic [DWIDTH-1:0] merge_data;
    logic [DWIDTH-1:0] load_data;
    logic [LANES-1:0]  lane_sel;

    logic              ready_next;
    logic              rsp_valid_next;
    logic              rsp_err_next;
    logic [DWIDTH-1:0] rsp_rdata_next;
    logic [AWIDTH-1:0] mem_addr_next;
    logic [DWIDTH-1:0] mem_data_next;
    logic              mem_rd_next;
    logic              mem_wr_next;

    always_comb begin
`ifdef MISALIGN_TRAP_EN
        req_bad = (bus.req_size_i == 2'b11)
               || (bus.req_size_i == 2'b01 && bus.req_addr_i[0])
               || (bus.req_size_i == 2'b10 && bus.req_addr_i[1:0] != 2'b00);
`else
        req_bad = (bus.req_size_i == 2'b11);
`endif
    end

    // Each byte lane takes store data if the access covers it, otherwise keeps the old byte.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            localparam bit LOW_BYTE = (gi == 0);
            localparam bit LOW_HALF = (gi < 2);
            assign lane_sel[gi] = LOW_BYTE
                               || (LOW_HALF && size_reg == 2'b01)
                               || (size_reg == 2'b10);
            assign merge_data[gi*8 +: 8] = lane_sel[gi] ? wdata_reg[gi*8 +: 8]
                                                        : old_reg[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        load_data = old_reg;
        case (size_reg)
            2'b00: load_data = uns_reg ? {{(DWIDTH-8){1'b0}}, old_reg[7:0]}
                                       : {{(DWIDTH-8){old_reg[7]}}, old_reg[7:0]};
            2'b01: load_data = uns_reg ? {{(DWIDTH-16){1'b0}}, old_reg[15:0]}
                                       : {{(DWIDTH-16){old_reg[15]}}, old_reg[15:0]};
            default: load_data = old_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            size_reg  <= 2'b00;
            uns_reg   <= 1'b0;
            wdata_reg <= '0;
            old_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && bus.req_valid_i) begin
                we_reg    <= bus.req_we_i;
                addr_reg  <= bus.req_addr_i;
                size_reg  <= bus.req_size_i;
                uns_reg   <= bus.req_unsigned_i;
                wdata_reg <= bus.req_wdata_i;
                err_reg   <= req_bad;
            end
            if (state_reg == ACCESS) begin
                old_reg <= bus.mem_data_i;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        ready_next     = 1'b0;
        rsp_valid_next = 1'b0;
        rsp_err_next   = 1'b0;
        rsp_rdata_next = '0;
        mem_addr_next  = '0;
        mem_data_next  = '0;
        mem_rd_next    = 1'b0;
        mem_wr_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                ready_next = 1'b1;
                if (bus.req_valid_i) begin
                    state_next = req_bad ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                mem_addr_next = addr_reg;
                if (we_reg && size_reg == 2'b10) begin
                    mem_wr_next   = 1'b1;
                    mem_data_next = wdata_reg;
                    state_next    = RESP;
                end else begin
                    mem_rd_next = 1'b1;
                    state_next  = we_reg ? WRITE : RESP;
                end
            end
            WRITE: begin
                mem_addr_next = addr_reg;
                mem_wr_next   = 1'b1;
                mem_data_next = merge_data;
                state_next    = RESP;
            end
            RESP: begin
                rsp_valid_next = 1'b1;
                rsp_err_next   = err_reg;
                rsp_rdata_next = (we_reg || err_reg) ? '0 : load_data;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.req_ready_o    = ready_next;
    assign bus.rsp_valid_o    = rsp_valid_next;
    assign bus.rsp_err_o      = rsp_err_next;
    assign bus.rsp_rdata_o    = rsp_rdata_next;
    assign bus.mem_addr_o     = mem_addr_next;
    assign bus.mem_data_o     = mem_data_next;
    assign bus.mem_read_en_o  = mem_rd_next;
    assign bus.mem_write_en_o = mem_wr_next;
endmodule

// File: tb/tb_mem_requester.sv
// Bench for mem_requester: byte-array memory, byte-level reference model, random and directed requests.
module tb_mem_requester;
    localparam logic [31:0] BASE = 32'h0100_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_requester_if #(.AWIDTH(32), .DWIDTH(32)) bus();

    mem_requester #(.AWIDTH(32), .DWIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int tests = 0;
    int fails = 0;

    // Memory as seen by the DUT (64 bytes, wraps), and the bench's own expected contents.
    logic [7:0] mem     [0:63];
    logic [7:0] ref_mem [0:63];
    logic       init_en = 1'b1;
    logic       preset_en = 1'b0;
    logic [5:0] preset_idx = '0;
    logic [31:0] preset_word = '0;

    logic [5:0] ri;
    assign ri = 6'(bus.mem_addr_o - BASE);
    assign bus.mem_data_i = {mem[ri + 6'd3], mem[ri + 6'd2], mem[ri + 6'd1], mem[ri]};

    always @(posedge clk) begin
        if (init_en) begin
            for (int k = 0; k < 64; k++) mem[k] <= 8'(k * 37 + 5);
        end else if (bus.mem_write_en_o) begin
            mem[ri]        <= bus.mem_data_o[7:0];
            mem[ri + 6'd1] <= bus.mem_data_o[15:8];
            mem[ri + 6'd2] <= bus.mem_data_o[23:16];
            mem[ri + 6'd3] <= bus.mem_data_o[31:24];
        end else if (preset_en) begin
            mem[preset_idx]        <= preset_word[7:0];
            mem[preset_idx + 6'd1] <= preset_word[15:8];
            mem[preset_idx + 6'd2] <= preset_word[23:16];
            mem[preset_idx + 6'd3] <= preset_word[31:24];
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic int unsigned idx(input logic [31:0] a);
        return (a - BASE) & 32'd63;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[k*8 +: 8] = ref_mem[idx(a + 32'(k))];
        return w;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[k*8 +: 8] = mem[idx(a + 32'(k))];
        return w;
    endfunction

    function automatic bit model_err(input logic [31:0] a, input logic [1:0] size);
        bit e;
        e = (size == 2'd3);
`ifdef MISALIGN_TRAP_EN
        if (size == 2'd1 && a[0]) e = 1'b1;
        if (size == 2'd2 && a[1:0] != 2'd0) e = 1'b1;
`endif
        return e;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] size, input bit uns);
        logic [31:0] w;
        logic [31:0] v;
        w = ref_word(a);
        if (size == 2'd0) begin
            v = w % 256;
            if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v = w % 65536;
            if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    task automatic preset(input logic [31:0] a, input logic [31:0] w);
        @(negedge clk);
        preset_idx  = 6'(idx(a));
        preset_word = w;
        preset_en   = 1'b1;
        for (int k = 0; k < 4; k++) ref_mem[idx(a + 32'(k))] = w[k*8 +: 8];
        @(negedge clk);
        preset_en = 1'b0;
    endtask

    task automatic do_req(input bit we, input logic [31:0] a, input logic [1:0] size,
                          input bit uns, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat);
        bit          e_err;
        int          e_lat, e_rd, e_wr, n_rd, n_wr, nbytes;
        logic [31:0] e_rdata;
        e_err   = model_err(a, size);
        e_rdata = (we || e_err) ? 32'd0 : model_load(a, size, uns);
        e_lat   = e_err ? 0 : ((we && size != 2'd2) ? 2 : 1);
        e_rd    = (e_err || (we && size == 2'd2)) ? 0 : 1;
        e_wr    = (!e_err && we) ? 1 : 0;
        @(negedge clk);
        check("ready_before_accept", 32'(bus.req_ready_o), 32'd1);
        bus.req_valid_i    = 1'b1;
        bus.req_we_i       = we;
        bus.req_addr_i     = a;
        bus.req_size_i     = size;
        bus.req_unsigned_i = uns;
        bus.req_wdata_i    = wdata;
        @(posedge clk);
        #1;
        bus.req_valid_i    = 1'b0;
        bus.req_we_i       = 1'($urandom);
        bus.req_addr_i     = $urandom;
        bus.req_size_i     = 2'($urandom);
        bus.req_unsigned_i = 1'($urandom);
        bus.req_wdata_i    = $urandom;
        lat = 0; n_rd = 0; n_wr = 0;
        while (!bus.rsp_valid_o && lat < 6) begin
            n_rd += int'(bus.mem_read_en_o);
            n_wr += int'(bus.mem_write_en_o);
            if (bus.mem_read_en_o || bus.mem_write_en_o) check("mem_addr", bus.mem_addr_o, a);
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= 6) begin
            tests++; fails++;
            $display("FAIL rsp_timeout: no rsp_valid after %0d cycles, expected after %0d", lat, e_lat);
        end
        rdata = bus.rsp_rdata_o;
        err   = bus.rsp_err_o;
        check("latency", 32'(lat), 32'(e_lat));
        check("rsp_err", 32'(err), 32'(e_err));
        check("rsp_rdata", rdata, e_rdata);
        check("read_cycles", 32'(n_rd), 32'(e_rd));
        check("write_cycles", 32'(n_wr), 32'(e_wr));
        @(posedge clk);
        #1;
        check("rsp_one_cycle", 32'(bus.rsp_valid_o), 32'd0);
        check("ready_after_resp", 32'(bus.req_ready_o), 32'd1);
        if (we && !e_err) begin
            nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
            for (int k = 0; k < nbytes; k++) ref_mem[idx(a + 32'(k))] = wdata[k*8 +: 8];
        end
        check("mem_contents", mem_word(a), ref_word(a));
    endtask

    // Every-cycle rules that hold regardless of the request being served.
    always @(negedge clk) begin
        if (!rst && !init_en) begin
            tests++;
            if ((bus.mem_read_en_o && bus.mem_write_en_o) ||
                (!bus.mem_write_en_o && bus.mem_data_o != 32'd0) ||
                ((bus.mem_read_en_o || bus.mem_write_en_o || bus.rsp_valid_o) && bus.req_ready_o) ||
                (bus.rsp_valid_o && (bus.mem_read_en_o || bus.mem_write_en_o))) begin
                fails++;
                $display("FAIL cycle_rules: rd=%b wr=%b data=%h ready=%b rsp=%b",
                         bus.mem_read_en_o, bus.mem_write_en_o, bus.mem_data_o,
                         bus.req_ready_o, bus.rsp_valid_o);
            end
        end
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lt;
        logic [31:0] a;
        logic [1:0]  sz;
        int          r;

        bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_addr_i = '0;
        bus.req_size_i = 2'd0; bus.req_unsigned_i = 1'b0; bus.req_wdata_i = '0;
        for (int k = 0; k < 64; k++) ref_mem[k] = 8'(k * 37 + 5);

        @(posedge clk);
        #1;
        check("reset_ready", 32'(bus.req_ready_o), 32'd1);
        check("reset_rsp", {bus.rsp_valid_o, bus.rsp_err_o, bus.mem_read_en_o, bus.mem_write_en_o}, 32'd0);
        check("reset_rdata", bus.rsp_rdata_o, 32'd0);
        check("reset_mem_addr", bus.mem_addr_o, 32'd0);
        check("reset_mem_data", bus.mem_data_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        init_en = 1'b0;

        // Load extension from 0x8001F0FF.
        preset(BASE, 32'h8001_F0FF);
        do_req(1'b0, BASE, 2'd0, 1'b0, 32'd0, rd, er, lt);
        check("lit_sbyte", rd, 32'hFFFF_FFFF);
        check("lit_load_lat", 32'(lt), 32'd1);
        do_req(1'b0, BASE, 2'd0, 1'b1, 32'd0, rd, er, lt);
        check("lit_ubyte", rd, 32'h0000_00FF);
        do_req(1'b0, BASE, 2'd1, 1'b0, 32'd0, rd, er, lt);
        check("lit_shalf", rd, 32'hFFFF_F0FF);
        do_req(1'b0, BASE, 2'd2, 1'b0, 32'd0, rd, er, lt);
        check("lit_word", rd, 32'h8001_F0FF);

        // Word store then read back.
        do_req(1'b1, BASE + 32'd4, 2'd2, 1'b0, 32'hDEAD_BEEF, rd, er, lt);
        check("lit_wstore_lat", 32'(lt), 32'd1);
        do_req(1'b0, BASE + 32'd4, 2'd2, 1'b0, 32'd0, rd, er, lt);
        check("lit_wstore_read", rd, 32'hDEAD_BEEF);

        // Byte store read-modify-write.
        preset(BASE + 32'd8, 32'h1122_3344);
        do_req(1'b1, BASE + 32'd8, 2'd0, 1'b0, 32'h0000_00AB, rd, er, lt);
        check("lit_bstore_lat", 32'(lt), 32'd2);
        do_req(1'b0, BASE + 32'd8, 2'd2, 1'b0, 32'd0, rd, er, lt);
        check("lit_bstore_read", rd, 32'h1122_33AB);

        // Misaligned half load and reserved size.
        preset(BASE, 32'h1122_3344);
        do_req(1'b0, BASE + 32'd1, 2'd1, 1'b1, 32'd0, rd, er, lt);
`ifdef MISALIGN_TRAP_EN
        check("lit_misalign_err", 32'(er), 32'd1);
        check("lit_misalign_lat", 32'(lt), 32'd0);
`else
        check("lit_misalign_half", rd, 32'h0000_2233);
`endif
        do_req(1'b1, BASE + 32'd12, 2'd3, 1'b0, 32'h5555_5555, rd, er, lt);
        check("lit_size11_err", 32'(er), 32'd1);
        check("lit_size11_lat", 32'(lt), 32'd0);

        // Reset while a byte store sits in ACCESS.
        preset(BASE + 32'd16, 32'h1122_3344);
        @(negedge clk);
        bus.req_valid_i = 1'b1; bus.req_we_i = 1'b1; bus.req_addr_i = BASE + 32'd16;
        bus.req_size_i = 2'd0; bus.req_unsigned_i = 1'b0; bus.req_wdata_i = 32'h0000_00AB;
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
        check("pre_reset_read_en", 32'(bus.mem_read_en_o), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_outputs", {bus.rsp_valid_o, bus.rsp_err_o, bus.mem_read_en_o, bus.mem_write_en_o}, 32'd0);
        check("midrst_addr", bus.mem_addr_o, 32'd0);
        check("midrst_data", bus.mem_data_o, 32'd0);
        check("midrst_rdata", bus.rsp_rdata_o, 32'd0);
        check("midrst_ready", 32'(bus.req_ready_o), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_response", 32'(bus.rsp_valid_o), 32'd0);
        check("midrst_mem", mem_word(BASE + 32'd16), 32'h1122_3344);

        // Random mix checked against the byte-level model.
        for (int n = 0; n < 250; n++) begin
            a  = BASE + 32'($urandom_range(0, 63));
            r  = int'($urandom_range(0, 9));
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            do_req(1'($urandom), a, sz, 1'($urandom), $urandom, rd, er, lt);
        end

        for (int k = 0; k < 64; k += 4) check("final_mem", mem_word(BASE + 32'(k)), ref_word(BASE + 32'(k)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
